// File: rtl/uart_frame_decoder.sv
// Receive-side frame decoder for the inter-board game link: pops bytes from a
// first-word-fall-through FIFO, reassembles chunked positions, tracks link health.
module uart_frame_decoder #(
  parameter int POS_W          = 10,
  parameter int SCORE_W        = 3,
  parameter int TIMEOUT_CYCLES = 10,
  parameter int ERR_W          = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         read_data,
  input  logic               rx_empty,
  output logic               rd_uart,
  output logic               connect_corrected,
  output logic               enemy_shooter,
  output logic               game_starts,
  output logic               is_shooted,
  output logic [POS_W-1:0]   keeper_pos,
  output logic [POS_W-1:0]   x_shooter,
  output logic [POS_W-1:0]   y_shooter,
  output logic [SCORE_W-1:0] opponent_score,
  output logic               keeper_upd,
  output logic               shot_upd,
  output logic               frame_err,
  output logic [ERR_W-1:0]   err_count
);

  localparam int              WD_W   = 16;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

  typedef enum logic [0:0] {IDLE = 1'b0, POP = 1'b1} state_t;

  state_t       state, state_next;
  logic         accept;
  logic [2:0]   opcode;
  logic [4:0]   payload;

  logic         kp_pend, kp_pend_next;
  logic [4:0]   kp_low, kp_low_next;
  logic [1:0]   stage, stage_next;
  logic [4:0]   x_lo, x_lo_next, x_hi, x_hi_next, y_lo, y_lo_next;
  logic [WD_W-1:0] wd, wd_next;

  logic               connect_next, enemy_next, game_next, shooted_next;
  logic [POS_W-1:0]   keeper_next, x_next, y_next;
  logic [SCORE_W-1:0] score_next;
  logic               keeper_upd_next, shot_upd_next, frame_err_next;

  // High chunks carry only POS_W-5 meaningful bits; the rest must be zero.
  function automatic logic hi_chunk_ok(input logic [4:0] p);
    hi_chunk_ok = ((p >> (POS_W - 5)) == 5'd0);
  endfunction

  function automatic logic score_ok(input logic [4:0] p);
    score_ok = ((p[2:0] >> SCORE_W) == 3'd0);
  endfunction

  function automatic logic [POS_W-1:0] join_pos(input logic [4:0] hi, input logic [4:0] lo);
    join_pos = POS_W'({hi, lo});
  endfunction

  assign opcode  = read_data[2:0];
  assign payload = read_data[7:3];
  assign accept  = (state == IDLE) && !rx_empty;

  // Next-state, decode and watchdog logic.
  always_comb begin
    state_next      = state;
    kp_pend_next    = kp_pend;
    kp_low_next     = kp_low;
    stage_next      = stage;
    x_lo_next       = x_lo;
    x_hi_next       = x_hi;
    y_lo_next       = y_lo;
    connect_next    = connect_corrected;
    enemy_next      = enemy_shooter;
    game_next       = game_starts;
    shooted_next    = is_shooted;
    keeper_next     = keeper_pos;
    x_next          = x_shooter;
    y_next          = y_shooter;
    score_next      = opponent_score;
    keeper_upd_next = 1'b0;
    shot_upd_next   = 1'b0;
    frame_err_next  = 1'b0;
    wd_next         = wd;

    case (state)
      IDLE:    state_next = accept ? POP : IDLE;
      POP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (accept) begin
      case (opcode)
        3'b000: begin
          case (payload)
            5'b11001: {connect_next, enemy_next, game_next} = 3'b111;
            5'b01001: {connect_next, enemy_next, game_next} = 3'b101;
            5'b00001: {connect_next, enemy_next, game_next} = 3'b100;
            default: begin
              {connect_next, enemy_next, game_next} = 3'b000;
              frame_err_next = 1'b1;
            end
          endcase
        end
        3'b001: begin
          kp_low_next  = payload;
          kp_pend_next = 1'b1;
        end
        3'b010: begin
          kp_pend_next = 1'b0;
          if (kp_pend && hi_chunk_ok(payload)) begin
            keeper_next     = join_pos(payload, kp_low);
            keeper_upd_next = 1'b1;
          end else begin
            frame_err_next = 1'b1;
          end
        end
        3'b011: begin
          x_lo_next  = payload;
          stage_next = 2'd1;
        end
        3'b100: begin
          if (stage == 2'd1 && hi_chunk_ok(payload)) begin
            x_hi_next  = payload;
            stage_next = 2'd2;
          end else begin
            frame_err_next = 1'b1;
            stage_next     = 2'd0;
          end
        end
        3'b101: begin
          if (stage == 2'd2) begin
            y_lo_next  = payload;
            stage_next = 2'd3;
          end else begin
            frame_err_next = 1'b1;
            stage_next     = 2'd0;
          end
        end
        3'b110: begin
          stage_next = 2'd0;
          if (stage == 2'd3 && hi_chunk_ok(payload)) begin
            x_next        = join_pos(x_hi, x_lo);
            y_next        = join_pos(payload, y_lo);
            shot_upd_next = 1'b1;
          end else begin
            frame_err_next = 1'b1;
          end
        end
        3'b111: begin
          if (score_ok(payload)) begin
            score_next   = payload[SCORE_W-1:0];
            shooted_next = payload[3];
          end else begin
            frame_err_next = 1'b1;
          end
        end
        default: frame_err_next = 1'b1;
      endcase
    end else begin
      frame_err_next = 1'b0;
    end

    // An accepted byte beats the watchdog reaching its limit in the same cycle.
    if (accept) begin
      wd_next = {WD_W{1'b0}};
    end else if (wd == WD_MAX) begin
      wd_next = wd;
    end else begin
      wd_next = wd + WD_W'(1);
    end

    if (!accept && wd_next == WD_MAX) begin
      connect_next = 1'b0;
    end else begin
      connect_next = connect_next;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      kp_pend           <= 1'b0;
      kp_low            <= 5'd0;
      stage             <= 2'd0;
      x_lo              <= 5'd0;
      x_hi              <= 5'd0;
      y_lo              <= 5'd0;
      wd                <= {WD_W{1'b0}};
      rd_uart           <= 1'b0;
      connect_corrected <= 1'b0;
      enemy_shooter     <= 1'b0;
      game_starts       <= 1'b0;
      is_shooted        <= 1'b0;
      keeper_pos        <= {POS_W{1'b0}};
      x_shooter         <= {POS_W{1'b0}};
      y_shooter         <= {POS_W{1'b0}};
      opponent_score    <= {SCORE_W{1'b0}};
      keeper_upd        <= 1'b0;
      shot_upd          <= 1'b0;
      frame_err         <= 1'b0;
      err_count         <= {ERR_W{1'b0}};
    end else begin
      state             <= state_next;
      kp_pend           <= kp_pend_next;
      kp_low            <= kp_low_next;
      stage             <= stage_next;
      x_lo              <= x_lo_next;
      x_hi              <= x_hi_next;
      y_lo              <= y_lo_next;
      wd                <= wd_next;
      rd_uart           <= accept;
      connect_corrected <= connect_next;
      enemy_shooter     <= enemy_next;
      game_starts       <= game_next;
      is_shooted        <= shooted_next;
      keeper_pos        <= keeper_next;
      x_shooter         <= x_next;
      y_shooter         <= y_next;
      opponent_score    <= score_next;
      keeper_upd        <= keeper_upd_next;
      shot_upd          <= shot_upd_next;
      frame_err         <= frame_err_next;
      if (frame_err_next && err_count != {ERR_W{1'b1}}) begin
        err_count <= err_count + ERR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed self-checking bench for uart_frame_decoder (POS_W=10 main instance,
// POS_W=8/SCORE_W=2 side instance for narrow-chunk and score-range checks).
module tb_uart_frame_decoder;

  localparam int TO = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] read_data = 8'h00;
  logic       rx_empty = 1'b1;

  logic       rd_uart, connect_corrected, enemy_shooter, game_starts, is_shooted;
  logic [9:0] keeper_pos, x_shooter, y_shooter;
  logic [2:0] opponent_score;
  logic       keeper_upd, shot_upd, frame_err;
  logic [7:0] err_count;

  logic       rd_b, conn_b, enemy_b, game_b, shooted_b;
  logic [7:0] keeper_b, x_b, y_b;
  logic [1:0] score_b;
  logic       kupd_b, supd_b, ferr_b;
  logic [7:0] ecnt_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_frame_decoder #(.POS_W(10), .SCORE_W(3), .TIMEOUT_CYCLES(TO), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .read_data(read_data), .rx_empty(rx_empty),
    .rd_uart(rd_uart), .connect_corrected(connect_corrected),
    .enemy_shooter(enemy_shooter), .game_starts(game_starts), .is_shooted(is_shooted),
    .keeper_pos(keeper_pos), .x_shooter(x_shooter), .y_shooter(y_shooter),
    .opponent_score(opponent_score), .keeper_upd(keeper_upd), .shot_upd(shot_upd),
    .frame_err(frame_err), .err_count(err_count)
  );

  uart_frame_decoder #(.POS_W(8), .SCORE_W(2), .TIMEOUT_CYCLES(TO), .ERR_W(8)) dut8 (
    .clk(clk), .rst(rst), .read_data(read_data), .rx_empty(rx_empty),
    .rd_uart(rd_b), .connect_corrected(conn_b),
    .enemy_shooter(enemy_b), .game_starts(game_b), .is_shooted(shooted_b),
    .keeper_pos(keeper_b), .x_shooter(x_b), .y_shooter(y_b),
    .opponent_score(score_b), .keeper_upd(kupd_b), .shot_upd(supd_b),
    .frame_err(ferr_b), .err_count(ecnt_b)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx_empty = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Second negedge always lands in an IDLE cycle whether called from IDLE or POP.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    @(negedge clk);
    read_data = b;
    rx_empty = 1'b0;
    @(posedge clk); #1;
    rx_empty = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_empty = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rd_uart, connect_corrected, enemy_shooter, game_starts, is_shooted,
         keeper_upd, shot_upd, frame_err} !== 8'h00) begin
      errors++; $display("FAIL reset_flags: got %b want 00000000", {rd_uart, connect_corrected,
        enemy_shooter, game_starts, is_shooted, keeper_upd, shot_upd, frame_err});
    end
    checks++;
    if ({keeper_pos, x_shooter, y_shooter, opponent_score, err_count} !== 41'd0) begin
      errors++; $display("FAIL reset_values: got %h want 0",
        {keeper_pos, x_shooter, y_shooter, opponent_score, err_count});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sync();
    do_reset();
    @(negedge clk);
    read_data = 8'hC8;
    rx_empty = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rd_uart !== 1'b1) begin errors++; $display("FAIL sync_rd: got %b want 1", rd_uart); end
    checks++;
    if ({connect_corrected, enemy_shooter, game_starts} !== 3'b111) begin
      errors++; $display("FAIL sync_c8: got %b want 111", {connect_corrected, enemy_shooter, game_starts});
    end
    @(posedge clk); #1;
    rx_empty = 1'b1;
    checks++;
    if (rd_uart !== 1'b0) begin errors++; $display("FAIL sync_rd_pulse: got %b want 0", rd_uart); end
    @(posedge clk); #1;
    checks++;
    if ({rd_uart, frame_err} !== 2'b00) begin
      errors++; $display("FAIL sync_no_redecode: got %b want 00", {rd_uart, frame_err});
    end
    send(8'h08);
    checks++;
    if ({connect_corrected, enemy_shooter, game_starts} !== 3'b100) begin
      errors++; $display("FAIL sync_08: got %b want 100", {connect_corrected, enemy_shooter, game_starts});
    end
    send(8'h48);
    checks++;
    if ({connect_corrected, enemy_shooter, game_starts} !== 3'b101) begin
      errors++; $display("FAIL sync_48: got %b want 101", {connect_corrected, enemy_shooter, game_starts});
    end
    send(8'hF8);
    checks++;
    if ({connect_corrected, enemy_shooter, game_starts, frame_err, err_count} !== {4'b0001, 8'd1}) begin
      errors++; $display("FAIL sync_bad: got %b/%0d want 0001/1",
        {connect_corrected, enemy_shooter, game_starts, frame_err}, err_count);
    end
  endtask

  task automatic test_keeper();
    do_reset();
    send(8'hA1);
    checks++;
    if (keeper_upd !== 1'b0) begin errors++; $display("FAIL keeper_lo_upd: got %b want 0", keeper_upd); end
    send(8'h1A);
    checks++;
    if ({keeper_upd, keeper_pos} !== {1'b1, 10'h074}) begin
      errors++; $display("FAIL keeper_pos: got %b/%h want 1/074", keeper_upd, keeper_pos);
    end
    checks++;
    if (keeper_b !== 8'h74) begin errors++; $display("FAIL keeper_pos8: got %h want 74", keeper_b); end
    @(posedge clk); #1;
    checks++;
    if (keeper_upd !== 1'b0) begin errors++; $display("FAIL keeper_upd_pulse: got %b want 0", keeper_upd); end
    send(8'hA1);
    send(8'h42);
    checks++;
    if ({ferr_b, kupd_b, keeper_b} !== {2'b10, 8'h74}) begin
      errors++; $display("FAIL keeper8_hi_bit3: got %b%b/%h want 10/74", ferr_b, kupd_b, keeper_b);
    end
    checks++;
    if ({frame_err, keeper_upd, keeper_pos} !== {2'b01, 10'h114}) begin
      errors++; $display("FAIL keeper10_wide_hi: got %b%b/%h want 01/114", frame_err, keeper_upd, keeper_pos);
    end
  endtask

  task automatic test_keeper_after_reset();
    do_reset();
    send(8'hA1);
    do_reset();
    send(8'h1A);
    checks++;
    if ({frame_err, keeper_upd, err_count, keeper_pos} !== {2'b10, 8'd1, 10'h000}) begin
      errors++; $display("FAIL keeper_lone_hi: got %b%b/%0d/%h want 10/1/000",
        frame_err, keeper_upd, err_count, keeper_pos);
    end
  endtask

  task automatic test_shot();
    do_reset();
    send(8'h63);
    send(8'h4C);
    send(8'h45);
    checks++;
    if ({shot_upd, x_shooter, y_shooter} !== 21'd0) begin
      errors++; $display("FAIL shot_early: got %b/%0d/%0d want 0/0/0", shot_upd, x_shooter, y_shooter);
    end
    send(8'h36);
    checks++;
    if ({shot_upd, frame_err, x_shooter, y_shooter} !== {2'b10, 10'd300, 10'd200}) begin
      errors++; $display("FAIL shot_update: got %b%b/%0d/%0d want 10/300/200",
        shot_upd, frame_err, x_shooter, y_shooter);
    end
    @(posedge clk); #1;
    checks++;
    if (shot_upd !== 1'b0) begin errors++; $display("FAIL shot_upd_pulse: got %b want 0", shot_upd); end
    send(8'h63);
    send(8'h45);
    checks++;
    if ({frame_err, shot_upd, x_shooter, y_shooter} !== {2'b10, 10'd300, 10'd200}) begin
      errors++; $display("FAIL shot_out_of_order: got %b%b/%0d/%0d want 10/300/200",
        frame_err, shot_upd, x_shooter, y_shooter);
    end
    send(8'h36);
    checks++;
    if ({frame_err, shot_upd} !== 2'b10) begin
      errors++; $display("FAIL shot_stage_reset: got %b%b want 10", frame_err, shot_upd);
    end
  endtask

  task automatic test_score();
    do_reset();
    send(8'h6F);
    checks++;
    if ({frame_err, is_shooted, opponent_score} !== {2'b01, 3'd5}) begin
      errors++; $display("FAIL score10: got %b%b/%0d want 01/5", frame_err, is_shooted, opponent_score);
    end
    checks++;
    if ({ferr_b, shooted_b, score_b} !== {2'b10, 2'd0}) begin
      errors++; $display("FAIL score8_range: got %b%b/%0d want 10/0", ferr_b, shooted_b, score_b);
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    @(negedge clk);
    read_data = 8'hC8;
    rx_empty = 1'b0;
    @(posedge clk); #1;
    rx_empty = 1'b1;
    checks++;
    if (connect_corrected !== 1'b1) begin errors++; $display("FAIL wd_up: got %b want 1", connect_corrected); end
    for (int i = 1; i < TO; i++) begin
      @(posedge clk); #1;
      checks++;
      if (connect_corrected !== 1'b1) begin
        errors++; $display("FAIL wd_hold_%0d: got %b want 1", i, connect_corrected);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (connect_corrected !== 1'b0) begin errors++; $display("FAIL wd_lost: got %b want 0", connect_corrected); end
  endtask

  task automatic test_watchdog_boundary();
    do_reset();
    @(negedge clk);
    read_data = 8'hC8;
    rx_empty = 1'b0;
    @(posedge clk); #1;
    rx_empty = 1'b1;
    repeat (TO - 1) @(posedge clk);
    @(negedge clk);
    read_data = 8'hC8;
    rx_empty = 1'b0;
    @(posedge clk); #1;
    rx_empty = 1'b1;
    checks++;
    if ({rd_uart, connect_corrected} !== 2'b11) begin
      errors++; $display("FAIL wd_boundary: got %b want 11", {rd_uart, connect_corrected});
    end
    @(posedge clk); #1;
    checks++;
    if (connect_corrected !== 1'b1) begin
      errors++; $display("FAIL wd_boundary_hold: got %b want 1", connect_corrected);
    end
  endtask

  task automatic test_err_saturation();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      send(8'hF8);
    end
    checks++;
    if ({frame_err, err_count} !== {1'b1, 8'd255}) begin
      errors++; $display("FAIL err_saturate: got %b/%0d want 1/255", frame_err, err_count);
    end
  endtask

  initial begin
    test_reset();
    test_sync();
    test_keeper();
    test_keeper_after_reset();
    test_shot();
    test_score();
    test_watchdog();
    test_watchdog_boundary();
    test_err_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
